// File: rtl/regfile_pkg.sv
// regfile_pkg
// Definitions shared by the register-file write path.
//   PC_INDEX           : architectural register that holds the program counter
//   DEF_WORD_SIZE      : default register data width
//   DEF_ADDR_WIDTH     : default register address width
//   REQ_ALU/LOAD/PC    : requester slot assignment on the write arbiter
package regfile_pkg;

  localparam int PC_INDEX       = 15;
  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_PC   = 2;

endpackage

// File: rtl/regfile_write_arbiter_rr_select.sv
// rr_select
// Purely combinational round-robin picker. Among the set bits of req, it
// selects the one reached first when scanning upward from index start,
// wrapping past N-1 back to 0.
// Ports:
//   req    in  N      request vector
//   start  in  PTR_W  index where the scan begins (must be < N)
//   grant  out N      one-hot grant, zero when req is zero
//   idx    out PTR_W  encoded index of the granted bit
//   found  out 1      a grant was made
module rr_select #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  // Circular distance from start; one extra bit covers i + N - start.
  logic [PTR_W:0] dist_s;
  logic [PTR_W:0] best_s;

  // Pick the valid request with the smallest circular distance from start.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    dist_s = '0;
    best_s = (PTR_W+1)'(N);
    for (int i = 0; i < N; i++) begin
      if ((PTR_W+1)'(i) >= {1'b0, start}) begin
        dist_s = (PTR_W+1)'(i) - {1'b0, start};
      end else begin
        dist_s = (PTR_W+1)'(i) + (PTR_W+1)'(N) - {1'b0, start};
      end
      if (req[i] && (dist_s < best_s)) begin
        best_s   = dist_s;
        grant    = '0;
        grant[i] = 1'b1;
        idx      = PTR_W'(i);
        found    = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port among NUM_REQ writeback
// sources with round-robin arbitration, registers the selected write and
// counts contended cycles (two or more valid requests), saturating.
// Optional feature macro: REGFILE_ARB_PC_PRIORITY_EN -- when defined, any
// valid request targeting the PC register wins ahead of round-robin
// (lowest index among PC requests), and rr_ptr is left untouched.
// Ports:
//   clk            in   1                    clock, posedge
//   reset          in   1                    synchronous, active-high
//   req_valid      in   NUM_REQ              request pending per requester
//   req_ready      out  NUM_REQ              combinational one-hot grant
//   req_reg        in   NUM_REQ*ADDR_WIDTH   packed target addresses
//   req_data       in   NUM_REQ*WORD_SIZE    packed write data
//   write_en       out  1                    registered write enable
//   write_reg      out  ADDR_WIDTH           registered write address
//   write_data     out  WORD_SIZE            registered write data
//   contention_cnt out  CNT_WIDTH            saturating contended-cycle count
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
  output logic                          write_en,
  output logic [ADDR_WIDTH-1:0]         write_reg,
  output logic [WORD_SIZE-1:0]          write_data,
  output logic [CNT_WIDTH-1:0]          contention_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr_r;
  logic [PTR_W-1:0]      rr_ptr_next_s;
  logic [NUM_REQ-1:0]    rr_grant_s;
  logic [PTR_W-1:0]      rr_idx_s;
  logic                  rr_found_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic                  grant_any_s;
  logic                  pc_win_s;
  logic [ADDR_WIDTH-1:0] sel_reg_s;
  logic [WORD_SIZE-1:0]  sel_data_s;
  logic                  multi_valid_s;

  rr_select #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req   (req_valid),
    .start (rr_ptr_r),
    .grant (rr_grant_s),
    .idx   (rr_idx_s),
    .found (rr_found_s)
  );

  // Final grant: round-robin result, optionally overridden by a PC write.
  always_comb begin
    grant_s     = rr_grant_s;
    grant_idx_s = rr_idx_s;
    grant_any_s = rr_found_s;
    pc_win_s    = 1'b0;
`ifdef REGFILE_ARB_PC_PRIORITY_EN
    // Descending scan so the lowest-indexed PC request is the last to win.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (req_reg[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(PC_INDEX))) begin
        pc_win_s    = 1'b1;
        grant_s     = '0;
        grant_s[i]  = 1'b1;
        grant_idx_s = PTR_W'(i);
        grant_any_s = 1'b1;
      end else begin
        pc_win_s = pc_win_s;
      end
    end
`endif
  end

  // No requester may transfer while reset is asserted.
  always_comb begin
    if (reset) begin
      req_ready = '0;
    end else begin
      req_ready = grant_s;
    end
  end

  // AND-OR mux of the granted requester's address and data.
  always_comb begin
    sel_reg_s  = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        sel_reg_s  = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = req_data[i*WORD_SIZE +: WORD_SIZE];
      end else begin
        sel_reg_s  = sel_reg_s;
      end
    end
  end

  // Pointer advances to the slot after the granted one, wrapping at NUM_REQ.
  always_comb begin
    if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
      rr_ptr_next_s = '0;
    end else begin
      rr_ptr_next_s = grant_idx_s + PTR_W'(1);
    end
  end

  // Clearing the lowest set bit leaves a nonzero value iff two or more are set.
  assign multi_valid_s = |(req_valid & (req_valid - NUM_REQ'(1)));

  // Output register, round-robin pointer and contention counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en       <= 1'b0;
      write_reg      <= '0;
      write_data     <= '0;
      rr_ptr_r       <= '0;
      contention_cnt <= '0;
    end else begin
      if (grant_any_s) begin
        write_en   <= 1'b1;
        write_reg  <= sel_reg_s;
        write_data <= sel_data_s;
      end else begin
        write_en   <= 1'b0;
      end
      if (grant_any_s && !pc_win_s) begin
        rr_ptr_r <= rr_ptr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (multi_valid_s && (contention_cnt != {CNT_WIDTH{1'b1}})) begin
        contention_cnt <= contention_cnt + CNT_WIDTH'(1);
      end else begin
        contention_cnt <= contention_cnt;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Self-checking bench: a reference model computes the expected grant each
// cycle and pushes the expected write into a scoreboard queue, which is
// popped and compared one cycle later against the registered outputs.
// Honours REGFILE_ARB_PC_PRIORITY_EN in its model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 3;
  localparam int CW   = 4;

  typedef struct packed {
    logic        en;
    logic [3:0]  rg;
    logic [31:0] dt;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [11:0]     req_reg;
  logic [95:0]     req_data;
  logic            write_en;
  logic [3:0]      write_reg;
  logic [31:0]     write_data;
  logic [CW-1:0]   contention_cnt;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_fail;
  int          ptr_m;
  int          cnt_m;
  logic [3:0]  hold_reg_m;
  logic [31:0] hold_data_m;
  logic [2:0]  exp_gnt;
  int          exp_idx;
  logic        exp_any;
  logic        exp_pc;
  logic        drop_on_grant;
  logic [31:0] rf_dut [16];

  regfile_write_arbiter #(
    .WORD_SIZE  (32),
    .ADDR_WIDTH (4),
    .NUM_REQ    (NREQ),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_reg        (req_reg),
    .req_data       (req_data),
    .write_en       (write_en),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] r, input logic [31:0] d);
    req_valid[i]         = 1'b1;
    req_reg[i*4 +: 4]    = r;
    req_data[i*32 +: 32] = d;
  endtask

  // Reference arbitration for the current inputs.
  task automatic model_grant();
    exp_gnt = 3'b000;
    exp_idx = 0;
    exp_any = 1'b0;
    exp_pc  = 1'b0;
    if (!reset) begin
`ifdef REGFILE_ARB_PC_PRIORITY_EN
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i] && req_reg[i*4 +: 4] == 4'd15) begin
          exp_idx = i;
          exp_any = 1'b1;
          exp_pc  = 1'b1;
        end
      end
`endif
      if (!exp_any) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (ptr_m + k) % NREQ;
          if (!exp_any && req_valid[c]) begin
            exp_idx = c;
            exp_any = 1'b1;
          end
        end
      end
      if (exp_any) exp_gnt[exp_idx] = 1'b1;
    end
  endtask

  // One clock cycle: entered just after a negedge with inputs driven.
  task automatic step();
    exp_t e;
    #1;
    model_grant();
    check_eq("req_ready", 64'(req_ready), 64'(exp_gnt));
    if (reset) begin
      hold_reg_m  = 4'd0;
      hold_data_m = 32'd0;
      sb_q.push_back('{en: 1'b0, rg: 4'd0, dt: 32'd0});
      cnt_m = 0;
      ptr_m = 0;
    end else begin
      if (exp_any) begin
        hold_reg_m  = req_reg[exp_idx*4 +: 4];
        hold_data_m = req_data[exp_idx*32 +: 32];
        if (!exp_pc) ptr_m = (exp_idx + 1) % NREQ;
      end
      sb_q.push_back('{en: exp_any, rg: hold_reg_m, dt: hold_data_m});
      if ($countones(req_valid) >= 2 && cnt_m != 15) cnt_m++;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("write_en", 64'(write_en), 64'(e.en));
    check_eq("write_reg", 64'(write_reg), 64'(e.rg));
    check_eq("write_data", 64'(write_data), 64'(e.dt));
    check_eq("contention_cnt", 64'(contention_cnt), 64'(cnt_m));
    if (write_en === 1'b1) rf_dut[write_reg] = write_data;
    @(negedge clk);
    if (drop_on_grant && exp_any) req_valid[exp_idx] = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    ptr_m         = 0;
    cnt_m         = 0;
    hold_reg_m    = 4'd0;
    hold_data_m   = 32'd0;
    drop_on_grant = 1'b0;
    for (int i = 0; i < 16; i++) rf_dut[i] = 32'd0;
    reset     = 1'b1;
    req_valid = 3'b000;
    req_reg   = 12'd0;
    req_data  = 96'd0;
    set_req(REQ_ALU, 4'd1, 32'h1111_0000);
    set_req(REQ_LOAD, 4'd2, 32'h2222_0000);
    set_req(REQ_PC, 4'd4, 32'h4444_0000);
    @(negedge clk);

    // Requests held through reset; no transfer allowed.
    repeat (3) step();
    // Full load from rr_ptr=0: grant order 0,1,2,0.
    reset = 1'b0;
    repeat (4) step();
    // Two requesters held: counter saturates.
    req_valid = 3'b011;
    repeat (20) step();

    // Reset arriving while a grant is live discards it.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 3'b000;
    drop_on_grant = 1'b1;
    step();

    // Single requester, then all three from rr_ptr=2: order 2,0,1.
    set_req(REQ_LOAD, 4'd3, 32'hDEAD_BEEF);
    repeat (2) step();
    set_req(0, 4'd7, 32'h0000_00A0);
    set_req(1, 4'd8, 32'h0000_00A1);
    set_req(2, 4'd9, 32'h0000_00A2);
    repeat (4) step();

    // Same-address pair: later grant wins.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 4'd5, 32'h0000_0001);
    set_req(1, 4'd5, 32'h0000_0002);
    repeat (3) step();
    check_eq("rf_r5_final", 64'(rf_dut[5]), 64'h2);

    // PC-targeting request against round-robin from rr_ptr=0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 4'd1, 32'h0000_AAAA);
    set_req(2, 4'd15, 32'h0000_BBBB);
    repeat (3) step();

    // Random traffic obeying the hold-until-granted rule.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 4'($urandom_range(0, 15)), $urandom);
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
